div_asm: RTL



---
 rtl/div_asm_pkg.sv | 15 +
 rtl/div_asm_if.sv | 25 ++
 rtl/div_asm_dp.sv | 72 +++++++
 rtl/div_asm.sv | 121 ++++++++++++
 4 files changed

// File: rtl/div_asm_pkg.sv
// div_asm shared types and defaults.
// FSM state encoding and default done-hold length.
package div_asm_pkg;

  typedef enum logic [2:0] {
    START = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    SUB   = 3'd3,
    END   = 3'd4
  } div_state_e;

  localparam int DONE_HOLD_DEF = 20;

endpackage

// File: rtl/div_asm_if.sv
// div_asm start/complete handshake and operand/result bus.
// master drives operands, slave returns results.
interface div_asm_if #(
  parameter int N = 8
);
  logic         init;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;
  logic         div_by_zero;

  modport master (
    output init, dividend, divisor,
    input  quotient, remainder,
    input  done, div_by_zero
  );

  modport slave (
    input  init, dividend, divisor,
    output quotient, remainder,
    output done, div_by_zero
  );
endinterface

// File: rtl/div_asm_dp.sv
// Restoring divider datapath: partial remainder, quotient
// shifter, divisor and iteration count.
module div_asm_dp #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         sub_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] q_nxt_o,
  output logic [N-1:0] rem_nxt_o,
  output logic         ge_o,
  output logic         cnt_zero_o
);

  localparam int CW = $clog2(N + 1);

  logic [N:0]    r_q, r_d, diff;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign diff = r_q - {1'b0, d_q};

  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      load_i: begin
        r_d   = '0;
        q_d   = dividend_i;
        d_d   = divisor_i;
        cnt_d = CW'(N);
      end
      shift_i: begin
        {r_d, q_d} = {r_q[N-1:0], q_q, 1'b0};
        cnt_d      = cnt_q - 1'b1;
      end
      sub_i: begin
        r_d = diff;
        q_d = {q_q[N-1:1], 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  // next values let the FSM capture results including a final SUB
  assign q_nxt_o    = q_d;
  assign rem_nxt_o  = r_d[N-1:0];
  assign ge_o       = (r_q >= {1'b0, d_q});
  assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/div_asm.sv
// Sequential unsigned restoring divider top: control FSM,
// done-hold timer and registered result outputs.
module div_asm
  import div_asm_pkg::*;
#(
  parameter int N         = 8,
  parameter int DONE_HOLD = DONE_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  div_asm_if.slave bus
);

  localparam int TW =
    (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;

  div_state_e    state_q, state_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic         load, shift, sub;
  logic         ge, cnt_zero;
  logic [N-1:0] q_nxt, rem_nxt;

  div_asm_dp #(.N(N)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_i    (shift),
    .sub_i      (sub),
    .dividend_i (bus.dividend),
    .divisor_i  (bus.divisor),
    .q_nxt_o    (q_nxt),
    .rem_nxt_o  (rem_nxt),
    .ge_o       (ge),
    .cnt_zero_o (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    sub     = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      START: begin
        done_d = 1'b0;
        if (bus.init && bus.divisor != '0) begin
          load    = 1'b1;
          dbz_d   = 1'b0;
          state_d = SHIFT;
        end else if (bus.init) begin
          quo_d   = '1;
          rem_d   = bus.dividend;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          tmr_d   = TW'(DONE_HOLD);
          state_d = END;
        end
      end
      SHIFT: begin
        shift   = 1'b1;
        state_d = CHECK;
      end
      CHECK, SUB: begin
        sub = (state_q == SUB);
        if (state_q == CHECK && ge) begin
          state_d = SUB;
        end else if (cnt_zero) begin
          quo_d   = q_nxt;
          rem_d   = rem_nxt;
          done_d  = 1'b1;
          tmr_d   = TW'(DONE_HOLD);
          state_d = END;
        end else begin
          state_d = SHIFT;
        end
      end
      END: begin
        if (tmr_q == '0) begin
          done_d  = 1'b0;
          state_d = START;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule
